// File: rtl/i2c_master_byte_ctrl_pkg.sv
// Shared command codes, FSM states and counter limits for the I2C byte-level master.
package pkg_i2c_master;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP
  } state_e;

  localparam logic [1:0] LAST_QUARTER = 2'd3;
  localparam logic [3:0] LAST_BIT     = 4'd8;

endpackage

// File: rtl/i2c_master_clkgen.sv
// SCL quarter-period divider: counts div+1 cycles per quarter, can be held at quarter start.
module i2c_master_clkgen #(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 hold_i,
  input  logic [CLK_DIV_W-1:0] div_i,
  output logic                 qstart_o,
  output logic                 qdone_o
);

  logic [CLK_DIV_W-1:0] cnt_q;
  logic [CLK_DIV_W-1:0] div_q;
  logic                 stall;

  // Stretching only freezes a quarter before it has begun counting.
  assign stall    = hold_i && (cnt_q == '0);
  assign qstart_o = en_i && (cnt_q == '0) && !hold_i;
  assign qdone_o  = en_i && !stall && (cnt_q == div_q);

  // The divisor is re-captured at every quarter boundary, so a change lands on the next quarter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (!en_i || qdone_o) begin
      cnt_q <= '0;
      div_q <= div_i;
    end else if (!stall) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: executes one START, STOP, WRITE or READ command at a time
// on an open-drain SCL/SDA pad pair, with clock stretching support.
module i2c_master_byte_ctrl
  import pkg_i2c_master::*;
#(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CLK_DIV_W-1:0] clk_div_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_i,
  input  logic [7:0]           wdata_i,
  input  logic                 ack_i,
  output logic                 rsp_valid_o,
  output logic                 rsp_nack_o,
  output logic [7:0]           rdata_o,
  output logic                 busy_o,
  input  logic                 scl_pad_i,
  output logic                 scl_pad_o,
  output logic                 scl_padoen_o,
  input  logic                 sda_pad_i,
  output logic                 sda_pad_o,
  output logic                 sda_padoen_o,
  output state_e               state_o
);

  // Handshake: a command transfers on any cycle with cmd_valid_i && cmd_ready_o; ready is
  // high only while idle, and completion is a single-cycle rsp_valid_o pulse with no back-pressure.

  state_e      state_q, state_d;
  logic [1:0]  phase_q;
  logic [3:0]  bit_q;
  cmd_e        cmd_q;
  logic [7:0]  wdata_q, rx_q, rdata_q;
  logic        ack_q, nack_tmp_q, rsp_nack_q, rsp_valid_q, busy_q;
  logic        scl_hold_q, sda_hold_q;
  logic        scl_oen, sda_oen, bit_sda;
  logic        en, hold, qstart, qdone, last_quarter, done, accept, sample;

  assign en           = (state_q != ST_IDLE);
  assign accept       = cmd_valid_i && cmd_ready_o;
  assign hold         = en && scl_oen && !scl_pad_i;
  assign last_quarter = (phase_q == LAST_QUARTER) && ((state_q != ST_BIT) || (bit_q == LAST_BIT));
  assign done         = qdone && last_quarter;
  assign sample       = (state_q == ST_BIT) && (phase_q == 2'd2) && qstart;

  i2c_master_clkgen #(.CLK_DIV_W(CLK_DIV_W)) u_clkgen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en),
    .hold_i   (hold),
    .div_i    (clk_div_i),
    .qstart_o (qstart),
    .qdone_o  (qdone)
  );

  always_comb begin
    bit_sda = 1'b1;
    if (bit_q == LAST_BIT) bit_sda = (cmd_q == CMD_WRITE) ? 1'b1 : ~ack_q;
    else if (cmd_q == CMD_WRITE) bit_sda = wdata_q[~bit_q[2:0]];
  end

  // Lines keep their last driven level while idle so the bus stays owned between commands.
  always_comb begin
    scl_oen = scl_hold_q;
    sda_oen = sda_hold_q;
    case (state_q)
      ST_START: begin
        case (phase_q)
          2'd0:    sda_oen = 1'b1;
          2'd1:    begin scl_oen = 1'b1; sda_oen = 1'b1; end
          2'd2:    begin scl_oen = 1'b1; sda_oen = 1'b0; end
          default: begin scl_oen = 1'b0; sda_oen = 1'b0; end
        endcase
      end
      ST_BIT: begin
        scl_oen = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_oen = bit_sda;
      end
      ST_STOP: begin
        case (phase_q)
          2'd0:    sda_oen = 1'b0;
          2'd3:    begin scl_oen = 1'b1; sda_oen = 1'b1; end
          default: begin scl_oen = 1'b1; sda_oen = 1'b0; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (cmd_valid_i) begin
        case (cmd_e'(cmd_i))
          CMD_START: state_d = ST_START;
          CMD_STOP:  state_d = ST_STOP;
          default:   state_d = ST_BIT;
        endcase
      end
    end else if (done) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q     <= '0;
      bit_q       <= '0;
      cmd_q       <= CMD_START;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      rx_q        <= '0;
      nack_tmp_q  <= 1'b0;
      rdata_q     <= '0;
      rsp_nack_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      scl_hold_q  <= 1'b1;
      sda_hold_q  <= 1'b1;
    end else begin
      rsp_valid_q <= done;
      if (accept) begin
        cmd_q   <= cmd_e'(cmd_i);
        wdata_q <= wdata_i;
        ack_q   <= ack_i;
        phase_q <= '0;
        bit_q   <= '0;
      end
      if (en) begin
        scl_hold_q <= scl_oen;
        sda_hold_q <= sda_oen;
      end
      if (qdone) begin
        phase_q <= phase_q + 2'd1;
        if ((state_q == ST_BIT) && (phase_q == LAST_QUARTER) && (bit_q != LAST_BIT))
          bit_q <= bit_q + 4'd1;
      end
      if (sample) begin
        if (bit_q == LAST_BIT) nack_tmp_q <= sda_pad_i;
        else                   rx_q       <= {rx_q[6:0], sda_pad_i};
      end
      if (done) begin
        case (cmd_q)
          CMD_START: busy_q     <= 1'b1;
          CMD_STOP:  busy_q     <= 1'b0;
          CMD_WRITE: rsp_nack_q <= nack_tmp_q;
          CMD_READ:  rdata_q    <= rx_q;
        endcase
      end
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_nack_o   = rsp_nack_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = busy_q;
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oen;
  assign sda_padoen_o = sda_oen;
  assign state_o      = state_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: open-drain bus with a behavioural slave and a timing/data model.
module tb_i2c_master_byte_ctrl;
  import pkg_i2c_master::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] clk_div = 16'd3;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [7:0]  wdata = 8'h00;
  logic        ack = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_nack, busy;
  logic [7:0]  rdata;
  logic        scl_o, sda_o, scl_oen, sda_oen;
  state_e      dbg_state;
  logic        scl_line, sda_line;

  int n_vec = 0;
  int n_err = 0;

  // slave model state
  logic       s_scl = 1'b1, s_sda = 1'b1;
  logic       s_active = 1'b0;
  int         s_mode = 0;
  int         s_bit = 0;
  logic [6:0] s_addr = 7'h50;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  logic       s_start = 1'b0, s_stop_o = 1'b0;
  logic       stretch_en = 1'b0;
  time        stretch_rel_t = 0;
  time        rise_t [9];
  logic       obs [9];

  assign scl_line = (scl_oen ? 1'b1 : scl_o) & s_scl;
  assign sda_line = (sda_oen ? 1'b1 : sda_o) & s_sda;

  i2c_master_byte_ctrl #(.CLK_DIV_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clk_div_i    (clk_div),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_i        (cmd),
    .wdata_i      (wdata),
    .ack_i        (ack),
    .rsp_valid_o  (rsp_valid),
    .rsp_nack_o   (rsp_nack),
    .rdata_o      (rdata),
    .busy_o       (busy),
    .scl_pad_i    (scl_line),
    .scl_pad_o    (scl_o),
    .scl_padoen_o (scl_oen),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_o),
    .sda_padoen_o (sda_oen),
    .state_o      (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // slave: start/stop detection
  always @(negedge sda_line) if (scl_line === 1'b1) s_start = 1'b1;
  always @(posedge sda_line) if (scl_line === 1'b1) s_stop_o = 1'b1;

  // slave: sample on SCL rise
  always @(posedge scl_line) begin
    if (s_active && s_bit < 9) begin
      rise_t[s_bit] = $time;
      obs[s_bit] = sda_line;
      if (s_mode == 0 && s_bit < 8) s_rx = {s_rx[6:0], sda_line};
    end
  end

  // slave: advance and drive on SCL fall
  always @(negedge scl_line) begin
    if (s_active) begin
      s_bit = s_bit + 1;
      if (s_bit < 8) s_sda = (s_mode == 1) ? s_tx[7 - s_bit] : 1'b1;
      else if (s_bit == 8) s_sda = (s_mode == 1) ? 1'b1 : !(s_rx[7:1] == s_addr);
      else begin s_sda = 1'b1; s_active = 1'b0; end
      if (stretch_en && s_bit == 3) begin
        s_scl = 1'b0;
        repeat (50) @(posedge clk);
        stretch_rel_t = $time;
        s_scl = 1'b1;
      end
    end
  end

  task automatic slave_begin(input int mode);
    s_mode = mode;
    s_bit = 0;
    s_rx = 8'h00;
    for (int i = 0; i < 9; i++) begin rise_t[i] = 0; obs[i] = 1'bx; end
    s_sda = (mode == 1) ? s_tx[7] : 1'b1;
    s_active = 1'b1;
  endtask

  function automatic logic [7:0] obs_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7 - i] = obs[i];
    return b;
  endfunction

  // driver: issue one command, wait (bounded) for its response pulse
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic a, output int cyc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; wdata = wd; ack = a;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd = 2'($urandom); wdata = 8'($urandom); ack = 1'($urandom);
    cyc = 0;
    while (!rsp_valid && cyc < 6000) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL rsp_timeout cmd=%0d waited %0d cycles, required a response", c, cyc);
    end else begin
      n_vec++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_at_rsp got %b exp 1", cmd_ready); end
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_single_pulse got %b exp 0", rsp_valid); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_vec++; if (rsp_nack !== 1'b0) begin n_err++; $display("FAIL reset_nack got %b exp 0", rsp_nack); end
    n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++;
    if ({scl_oen, sda_oen, scl_o, sda_o} !== 4'b1100) begin
      n_err++; $display("FAIL reset_pads got %b exp 1100", {scl_oen, sda_oen, scl_o, sda_o});
    end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_start_write_ack();
    int cyc;
    clk_div = 16'd3; s_addr = 7'h50; s_start = 1'b0;
    do_cmd(CMD_START, 8'h00, 1'b0, cyc);
    n_vec++; if (cyc != 16) begin n_err++; $display("FAIL start_latency got %0d exp 16", cyc); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy got %b exp 1", busy); end
    n_vec++; if (s_start !== 1'b1) begin n_err++; $display("FAIL start_condition got %b exp 1", s_start); end
    slave_begin(0);
    do_cmd(CMD_WRITE, 8'hA0, 1'b0, cyc);
    n_vec++; if (cyc != 144) begin n_err++; $display("FAIL write_latency got %0d exp 144", cyc); end
    n_vec++; if (obs_byte() !== 8'hA0) begin n_err++; $display("FAIL write_sda_bits got %h exp a0", obs_byte()); end
    n_vec++;
    if (rise_t[1] - rise_t[0] != 160) begin
      n_err++; $display("FAIL scl_period got %0t exp 160", rise_t[1] - rise_t[0]);
    end
    n_vec++; if (rsp_nack !== 1'b0) begin n_err++; $display("FAIL write_ack_nack got %b exp 0", rsp_nack); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy got %b exp 1", busy); end
  endtask

  task automatic test_write_nack();
    int cyc;
    clk_div = 16'd3;
    slave_begin(0);
    do_cmd(CMD_WRITE, 8'h22, 1'b0, cyc);
    n_vec++; if (cyc != 144) begin n_err++; $display("FAIL nack_latency got %0d exp 144", cyc); end
    n_vec++; if (rsp_nack !== 1'b1) begin n_err++; $display("FAIL write_nack got %b exp 1", rsp_nack); end
    n_vec++; if (obs_byte() !== 8'h22) begin n_err++; $display("FAIL nack_sda_bits got %h exp 22", obs_byte()); end
  endtask

  task automatic test_random_write();
    int cyc, d;
    logic [7:0] b;
    logic exp_nack;
    for (int k = 0; k < 5; k++) begin
      d = $urandom_range(0, 4);
      clk_div = 16'(d);
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b[7:1] = s_addr;
      exp_nack = (b[7:1] != s_addr);
      slave_begin(0);
      do_cmd(CMD_WRITE, b, 1'($urandom), cyc);
      n_vec++; if (cyc != 36 * (d + 1)) begin n_err++; $display("FAIL rwr_latency div=%0d got %0d exp %0d", d, cyc, 36 * (d + 1)); end
      n_vec++; if (obs_byte() !== b) begin n_err++; $display("FAIL rwr_bits got %h exp %h", obs_byte(), b); end
      n_vec++; if (rsp_nack !== exp_nack) begin n_err++; $display("FAIL rwr_nack got %b exp %b", rsp_nack, exp_nack); end
      n_vec++;
      if (rise_t[5] - rise_t[4] != 40 * (d + 1)) begin
        n_err++; $display("FAIL rwr_period got %0t exp %0d", rise_t[5] - rise_t[4], 40 * (d + 1));
      end
    end
  endtask

  task automatic test_read();
    int cyc, d;
    logic a;
    clk_div = 16'd3;
    s_tx = 8'h5A;
    slave_begin(1);
    do_cmd(CMD_READ, 8'($urandom), 1'b0, cyc);
    n_vec++; if (cyc != 144) begin n_err++; $display("FAIL read_latency got %0d exp 144", cyc); end
    n_vec++; if (rdata !== 8'h5A) begin n_err++; $display("FAIL read_data got %h exp 5a", rdata); end
    n_vec++; if (obs[8] !== 1'b1) begin n_err++; $display("FAIL read_nack_bit got %b exp 1", obs[8]); end
    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(0, 3);
      clk_div = 16'(d);
      s_tx = 8'($urandom);
      a = 1'($urandom);
      slave_begin(1);
      do_cmd(CMD_READ, 8'($urandom), a, cyc);
      n_vec++; if (rdata !== s_tx) begin n_err++; $display("FAIL rrd_data got %h exp %h", rdata, s_tx); end
      n_vec++; if (obs[8] !== ~a) begin n_err++; $display("FAIL rrd_ack_bit got %b exp %b", obs[8], ~a); end
      n_vec++; if (cyc != 36 * (d + 1)) begin n_err++; $display("FAIL rrd_latency got %0d exp %0d", cyc, 36 * (d + 1)); end
    end
  endtask

  task automatic test_stretch();
    int cyc;
    logic [7:0] b;
    clk_div = 16'd3;
    b = {s_addr, 1'($urandom)};
    stretch_rel_t = 0;
    stretch_en = 1'b1;
    slave_begin(0);
    do_cmd(CMD_WRITE, b, 1'b0, cyc);
    stretch_en = 1'b0;
    n_vec++;
    if (stretch_rel_t == 0 || rise_t[3] < stretch_rel_t) begin
      n_err++; $display("FAIL stretch_high_after_release rise %0t release %0t", rise_t[3], stretch_rel_t);
    end
    n_vec++;
    if (rise_t[3] - rise_t[2] < 500) begin
      n_err++; $display("FAIL stretch_gap got %0t exp >=500", rise_t[3] - rise_t[2]);
    end
    n_vec++; if (obs_byte() !== b) begin n_err++; $display("FAIL stretch_bits got %h exp %h", obs_byte(), b); end
    n_vec++; if (rsp_nack !== 1'b0) begin n_err++; $display("FAIL stretch_nack got %b exp 0", rsp_nack); end
    n_vec++; if (cyc <= 144) begin n_err++; $display("FAIL stretch_latency got %0d exp >144", cyc); end
  endtask

  task automatic test_stop();
    int cyc;
    clk_div = 16'd2;
    do_cmd(CMD_START, 8'h00, 1'b0, cyc);
    s_tx = 8'($urandom);
    slave_begin(1);
    do_cmd(CMD_READ, 8'h00, 1'b0, cyc);
    n_vec++; if (rdata !== s_tx) begin n_err++; $display("FAIL stop_read_data got %h exp %h", rdata, s_tx); end
    s_stop_o = 1'b0;
    do_cmd(CMD_STOP, 8'h00, 1'b0, cyc);
    n_vec++; if (cyc != 12) begin n_err++; $display("FAIL stop_latency got %0d exp 12", cyc); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %b exp 0", busy); end
    n_vec++; if (s_stop_o !== 1'b1) begin n_err++; $display("FAIL stop_condition got %b exp 1", s_stop_o); end
    n_vec++;
    if ({scl_line, sda_line} !== 2'b11) begin
      n_err++; $display("FAIL stop_lines got %b exp 11", {scl_line, sda_line});
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n;
    logic seen;
    clk_div = 16'd3;
    do_cmd(CMD_START, 8'h00, 1'b0, cyc);
    slave_begin(0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = CMD_WRITE; wdata = 8'($urandom);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (s_bit < 4 && n < 2000) begin @(posedge clk); n++; end
    n_vec++; if (n >= 2000) begin n_err++; $display("FAIL rstmid_reach_bit4 waited %0d cycles", n); end
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({scl_oen, sda_oen} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_padoen got %b exp 11", {scl_oen, sda_oen});
    end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b exp 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_active = 1'b0; s_sda = 1'b1;
    seen = 1'b0;
    repeat (200) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_rsp got %b exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_start_write_ack();
    test_write_nack();
    test_random_write();
    test_read();
    test_stretch();
    test_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
